// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the FSM state enum and a one-hot to index encoder.
package arb_pkg;

    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        TURN    = 2'd2
    } arb_state_t;

    // Index of the set bit; 0 for an all-zero vector.
    function automatic logic [MAX_ID_W-1:0] onehot_to_idx(
        input logic [MAX_REQ-1:0] vec
    );
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) idx = MAX_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Ports: req (requests), ptr (last winner) -> pick (one-hot), pick_valid.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] pick,
    output logic             pick_valid
);

    // Doubling the vector turns the wrap-around search into a
    // straight scan from ptr+1 upwards.
    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] pick_dbl;
    logic [ID_W:0]      idx;

    assign req_dbl = {req, req};

    always_comb begin
        pick_dbl   = '0;
        pick_valid = 1'b0;
        idx        = '0;
        // Scan from lowest priority down so the nearest hit wins.
        for (int k = N_REQ; k >= 1; k--) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (req_dbl[idx]) begin
                pick_dbl      = '0;
                pick_dbl[idx] = 1'b1;
                pick_valid    = 1'b1;
            end
        end
    end

    // Fold the upper copy back onto the real requester positions.
    assign pick = pick_dbl[N_REQ-1:0] | pick_dbl[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with hold limit and one-cycle owner turnaround.
// Ports: clk, rst (sync, high), req -> gnt, gnt_valid, gnt_id, timeout.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int MAX_HOLD = 16,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
    localparam logic [ID_W-1:0]   PTR_RST  = ID_W'(N_REQ - 1);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              timeout_q, timeout_d;

    logic [N_REQ-1:0]  pick;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic              owner_req;
    logic              at_limit;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    assign pick_id   = ID_W'(onehot_to_idx(MAX_REQ'(pick)));
    assign owner_req = |(req & gnt_q);
    assign at_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            IDLE, TURN: begin
                // TURN arbitrates too, so a new owner follows one gap.
                gnt_d      = '0;
                gnt_id_d   = '0;
                hold_cnt_d = '0;
                state_d    = IDLE;
                if (pick_valid) begin
                    state_d    = GRANTED;
                    gnt_d      = pick;
                    gnt_id_d   = pick_id;
                    ptr_d      = pick_id;
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            GRANTED: begin
                if (!owner_req) begin
                    state_d    = TURN;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                end else if (at_limit) begin
                    state_d    = TURN;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_id_d   = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_RST;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N_REQ=4, MAX_HOLD=4).
// Owner/tenure model checked every cycle plus literal spot checks.
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: current owner (-1 = none), last winner, tenure length.
    int owner  = -1;
    int last   = N - 1;
    int tenure = 0;
    bit exp_to = 1'b0;

    rr_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        exp_to = 1'b0;
        if (rst) begin
            owner  = -1;
            last   = N - 1;
            tenure = 0;
        end else if (owner >= 0) begin
            if (!req[owner]) begin
                owner = -1;
            end else if (tenure == MH) begin
                owner  = -1;
                exp_to = 1'b1;
            end else begin
                tenure++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (last + k) % N;
                if (owner < 0 && req[i]) begin
                    owner  = i;
                    last   = i;
                    tenure = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] eg;
            logic [1:0]   eid;
            eg  = '0;
            eid = '0;
            if (owner >= 0) begin
                eg[owner] = 1'b1;
                eid       = 2'(owner);
            end
            n_cmp++;
            if (gnt !== eg || gnt_id !== eid || gnt_valid !== (owner >= 0)
                || timeout !== exp_to) begin
                n_bad++;
                $display("FAIL model t=%0t: gnt=%b id=%0d v=%b to=%b required gnt=%b id=%0d v=%b to=%b",
                         $time, gnt, gnt_id, gnt_valid, timeout,
                         eg, eid, (owner >= 0), exp_to);
            end
        end
    end

    task automatic lit(input string nm, input logic [N-1:0] eg, input logic eto);
        n_cmp++;
        if (gnt !== eg || timeout !== eto) begin
            n_bad++;
            $display("FAIL %s: gnt=%b timeout=%b required gnt=%b timeout=%b",
                     nm, gnt, timeout, eg, eto);
        end
    endtask

    task automatic tn();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(negedge clk);
        lit("rst_hold", 4'b0000, 1'b0);
        tn();
        lit("rst_hold2", 4'b0000, 1'b0);
        rst = 1'b0;
        tn();
        lit("rst_first", 4'b0001, 1'b0);
        repeat (3) tn();
        lit("rot_hold4", 4'b0001, 1'b0);
        tn();
        lit("rot_to0", 4'b0000, 1'b1);
        tn();
        lit("rot_g1", 4'b0010, 1'b0);
        repeat (4) tn();
        lit("rot_to1", 4'b0000, 1'b1);
        tn();
        lit("rot_g2", 4'b0100, 1'b0);
        repeat (5) tn();
        lit("rot_g3", 4'b1000, 1'b0);
        repeat (5) tn();
        lit("rot_wrap", 4'b0001, 1'b0);

        req = 4'b0000;
        tn();
        lit("drop_all", 4'b0000, 1'b0);
        tn();
        req = 4'b0100;
        tn();
        lit("vol_g1", 4'b0100, 1'b0);
        tn();
        tn();
        lit("vol_g3", 4'b0100, 1'b0);
        req = 4'b0000;
        tn();
        lit("vol_rel", 4'b0000, 1'b0);
        tn();
        lit("vol_idle", 4'b0000, 1'b0);

        req = 4'b0010;
        tn();
        lit("sole_g", 4'b0010, 1'b0);
        repeat (3) tn();
        lit("sole_g4", 4'b0010, 1'b0);
        tn();
        lit("sole_to", 4'b0000, 1'b1);
        tn();
        lit("sole_regrant", 4'b0010, 1'b0);
        repeat (3) tn();
        tn();
        lit("sole_to2", 4'b0000, 1'b1);
        tn();
        repeat (3) tn();
        lit("lim_g4", 4'b0010, 1'b0);
        req = 4'b0000;
        tn();
        lit("drop_at_limit", 4'b0000, 1'b0);

        req = 4'b1000;
        tn();
        lit("mid_g3", 4'b1000, 1'b0);
        tn();
        rst = 1'b1;
        req = 4'b1001;
        tn();
        lit("mid_rst", 4'b0000, 1'b0);
        rst = 1'b0;
        tn();
        lit("mid_ptr", 4'b0001, 1'b0);
        req = 4'b0010;
        tn();
        tn();
        lit("mid2_g1", 4'b0010, 1'b0);
        rst = 1'b1;
        req = 4'b0110;
        tn();
        lit("mid2_rst", 4'b0000, 1'b0);
        rst = 1'b0;
        tn();
        lit("mid2_ptr", 4'b0010, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
            rst = ($urandom_range(99) == 0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        req = 4'b0000;
        repeat (3) tn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
